// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order word reads to instruction memory,
// buffers responses in a small prefetch FIFO and hands {pc, instruction}
// pairs to decode. A branch redirect flushes the FIFO and discards any
// responses still in flight for the abandoned path.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Credit limit widened by one bit so the sum of two counters never wraps.
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Redirect targets are always word addresses; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    state_t          state_r;
    logic [31:0]     fetch_pc_r;
    logic [31:0]     resp_pc_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   drop_cnt_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [31:0]     pc_mem_r   [DEPTH];
    logic [31:0]     data_mem_r [DEPTH];

    logic            head_valid_s;
    logic            credit_ok_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            push_s;
    logic            pop_s;
    logic [CW-1:0]   drop_sum_s;
    logic [31:0]     redirect_target_s;

    // Handshake decode: credit check, request/push/pop strobes, redirect bookkeeping.
    always_comb begin
        head_valid_s      = (count_r != CNT_ZERO);
        // Buffered entries plus in-flight requests may never exceed the FIFO size,
        // which is what lets responses arrive without any backpressure.
        credit_ok_s       = (({1'b0, count_r} + {1'b0, outstanding_r}) < DEPTH_C);
        req_valid_s       = (state_r == ST_RUN) && credit_ok_s && !redirect_valid;
        req_fire_s        = req_valid_s && imem_req_ready;
        push_s            = (state_r == ST_RUN) && (drop_cnt_r == CNT_ZERO) &&
                            imem_resp_valid && !redirect_valid;
        pop_s             = head_valid_s && inst_ready && !redirect_valid;
        // Everything still owed by memory becomes garbage, except a response
        // arriving right now, which is discarded on the spot.
        drop_sum_s        = drop_cnt_r + outstanding_r - CW'(imem_resp_valid);
        redirect_target_s = align_word(redirect_pc);
    end

    // Output drive: request side straight from fetch state, decode side from FIFO head.
    always_comb begin
        imem_req_valid = req_valid_s;
        imem_req_addr  = fetch_pc_r;
        inst_valid     = head_valid_s;
        if (head_valid_s) begin
            inst_data = data_mem_r[rd_ptr_r];
            inst_pc   = pc_mem_r[rd_ptr_r];
        end else begin
            inst_data = 32'h0000_0000;
            inst_pc   = 32'h0000_0000;
        end
    end

    // Fetch FSM with request/response counters and FIFO pointer management.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_BOOT;
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= CNT_ZERO;
            drop_cnt_r    <= CNT_ZERO;
            count_r       <= CNT_ZERO;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
        end else if (redirect_valid) begin
            // Redirect overrides every state and any same-cycle pop or push.
            fetch_pc_r    <= redirect_target_s;
            resp_pc_r     <= redirect_target_s;
            outstanding_r <= CNT_ZERO;
            drop_cnt_r    <= drop_sum_s;
            count_r       <= CNT_ZERO;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            state_r       <= (drop_sum_s != CNT_ZERO) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (req_fire_s) begin
                        fetch_pc_r <= fetch_pc_r + 32'd4;
                    end
                    if (push_s) begin
                        resp_pc_r <= resp_pc_r + 32'd4;
                        wr_ptr_r  <= wr_ptr_r + PTR_ONE;
                    end
                    if (pop_s) begin
                        rd_ptr_r <= rd_ptr_r + PTR_ONE;
                    end
                    outstanding_r <= outstanding_r + CW'(req_fire_s) - CW'(push_s);
                    count_r       <= count_r + CW'(push_s) - CW'(pop_s);
                end
                ST_FLUSH: begin
                    // Leave only once the counter already reads zero, so the
                    // cycle in which the last stale response lands stays quiet.
                    if (drop_cnt_r == CNT_ZERO) begin
                        state_r <= ST_RUN;
                    end else if (imem_resp_valid) begin
                        drop_cnt_r <= drop_cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_BOOT;
                end
            endcase
        end
    end

    // Prefetch FIFO storage: capture {resp_pc, data} at the write pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= 32'h0000_0000;
                data_mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= resp_pc_r;
            data_mem_r[wr_ptr_r] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order memory model with programmable latency
// answers requests, a scoreboard queue holds the expected {pc} sequence and
// a monitor compares every instruction decode consumes.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;
    int base_edge = 0;

    // Scoreboard of expected pcs in delivery order.
    logic [31:0] exp_q [$];
    int          n_pops = 0;
    int          first_pop = 0;
    int          last_pop = 0;
    logic [31:0] mon_e;

    // Memory model state.
    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;
    pend_t       pend [$];
    int          lat = 1;
    int          hs_cnt = 0;
    logic [31:0] exp_req_addr = 32'h0;
    bit          sb_auto = 1'b0;
    bit          prev_stall = 1'b0;
    bit          prev_redir = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Posedge counter used to timestamp handshakes and pops.
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Memory model: drive due responses at negedge, capture accepted requests shortly after.
    always begin
        @(negedge clock);
        if (!reset) begin
            pend.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
            prev_stall      = 1'b0;
            prev_redir      = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= edge_cnt + 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #2;
        if (reset) begin
            if (prev_stall && !redirect_valid && !prev_redir) begin
                chk("stall_valid", 32'(imem_req_valid), 32'd1);
                chk("stall_addr", imem_req_addr, prev_addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_req_addr);
                if (sb_auto) exp_q.push_back(exp_req_addr);
                exp_req_addr = exp_req_addr + 32'd4;
                hs_cnt++;
                pend.push_back('{edge_cnt + 1 + lat, imem_req_addr});
            end
            prev_stall = imem_req_valid && !imem_req_ready;
            prev_addr  = imem_req_addr;
            prev_redir = redirect_valid;
        end
    end

    // Monitor: compare every consumed instruction against the scoreboard head.
    always begin
        @(negedge clock);
        #2;
        if (reset) begin
            if (!inst_valid) begin
                chk("idle_data", inst_data, 32'h0);
                chk("idle_pc", inst_pc, 32'h0);
            end else if (inst_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pop: got pc %h expected none", inst_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("inst_pc", inst_pc, mon_e);
                    chk("inst_data", inst_data, mem_word(mon_e));
                end
                if (n_pops == 0) first_pop = edge_cnt + 1;
                last_pop = edge_cnt + 1;
                n_pops++;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_inst_data"}, inst_data, 32'h0);
        chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    endtask

    // Hold reset two cycles, clear bench state, release at a negedge (that is N1).
    task automatic do_reset();
        @(negedge clock);
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #2;
        chk_reset_outputs("reset");
        step(2);
        exp_q.delete();
        exp_req_addr = 32'h0;
        hs_cnt       = 0;
        n_pops       = 0;
        sb_auto      = 1'b0;
        @(negedge clock);
        reset     = 1'b1;
        base_edge = edge_cnt;
    endtask

    logic [39:0] pat;

    initial begin
        // Test 1: streaming, latency 1, one instruction per cycle.
        do_reset();
        lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        #2 chk("boot_no_req", 32'(imem_req_valid), 32'd0);
        step(1);
        #2 chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        step(8);
        imem_req_ready = 1'b0;
        step(6);
        chk("t1_hs", 32'(hs_cnt), 32'd8);
        chk("t1_drained", 32'(exp_q.size()), 32'd0);
        chk("t1_first_pop", 32'(first_pop - base_edge), 32'd4);
        chk("t1_span", 32'(last_pop - first_pop), 32'd7);

        // Test 2: decode stalled, credit limits to DEPTH requests.
        do_reset();
        lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
        step(10);
        #2 chk("t2_hs", 32'(hs_cnt), 32'd4);
        chk("t2_req_blocked", 32'(imem_req_valid), 32'd0);
        chk("t2_head_valid", 32'(inst_valid), 32'd1);
        chk("t2_head_pc", inst_pc, 32'h0);
        step(1);
        imem_req_ready = 1'b0; inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
        step(8);
        chk("t2_drained", 32'(exp_q.size()), 32'd0);
        chk("t2_pops", 32'(n_pops), 32'd4);
        chk("t2_span", 32'(last_pop - first_pop), 32'd3);

        // Test 3: redirect with two requests in flight, latency 3.
        do_reset();
        lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
        exp_q.push_back(32'h100);
        step(3);
        redirect_valid = 1'b1; redirect_pc = 32'h100; exp_req_addr = 32'h100;
        step(1);
        redirect_valid = 1'b0;
        #2 chk("t3_flush_c1", 32'(imem_req_valid), 32'd0);
        step(1);
        #2 chk("t3_flush_c2", 32'(imem_req_valid), 32'd0);
        step(1);
        #2 chk("t3_flush_c3", 32'(imem_req_valid), 32'd0);
        step(1);
        #2 chk("t3_resume_valid", 32'(imem_req_valid), 32'd1);
        chk("t3_resume_addr", imem_req_addr, 32'h100);
        step(1);
        imem_req_ready = 1'b0;
        step(8);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);
        chk("t3_hs", 32'(hs_cnt), 32'd3);

        // Test 4: redirect coinciding with a response and a pop, latency 2.
        do_reset();
        lat = 2; imem_req_ready = 1'b1; inst_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h40);
        step(5);
        redirect_valid = 1'b1; redirect_pc = 32'h40; exp_req_addr = 32'h40;
        #2 chk("t4_pre_head_pc", inst_pc, 32'h4);
        step(1);
        redirect_valid = 1'b0;
        #2 chk("t4_cleared", 32'(inst_valid), 32'd0);
        chk("t4_flush_c1", 32'(imem_req_valid), 32'd0);
        step(1);
        #2 chk("t4_flush_c2", 32'(imem_req_valid), 32'd0);
        step(1);
        #2 chk("t4_resume_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_resume_addr", imem_req_addr, 32'h40);
        step(1);
        imem_req_ready = 1'b0;
        step(8);
        chk("t4_drained", 32'(exp_q.size()), 32'd0);
        chk("t4_hs", 32'(hs_cnt), 32'd5);

        // Test 5: request-side ready toggling in a fixed pattern.
        do_reset();
        lat = 1; inst_ready = 1'b1; sb_auto = 1'b1;
        pat = 40'hB3_6D_C9_5A_E7;
        imem_req_ready = pat[0];
        for (int i = 1; i < 40; i++) begin
            step(1);
            imem_req_ready = pat[i];
        end
        step(1);
        imem_req_ready = 1'b0;
        step(8);
        sb_auto = 1'b0;
        chk("t5_drained", 32'(exp_q.size()), 32'd0);
        chk("t5_all_delivered", 32'(n_pops), 32'(hs_cnt));

        // Test 6: unaligned redirect, then reset asserted during FLUSH.
        do_reset();
        lat = 3; imem_req_ready = 1'b0; inst_ready = 1'b1;
        step(1);
        redirect_valid = 1'b1; redirect_pc = 32'h203; exp_req_addr = 32'h200;
        step(1);
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #2 chk("t6_align_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_align_addr", imem_req_addr, 32'h200);
        step(2);
        redirect_valid = 1'b1; redirect_pc = 32'h300; exp_req_addr = 32'h300;
        step(1);
        redirect_valid = 1'b0;
        #1 chk("t6_flush_addr", imem_req_addr, 32'h300);
        reset = 1'b0;
        #1 chk_reset_outputs("t6_midflush");
        step(2);
        exp_q.delete();
        exp_req_addr = 32'h0; hs_cnt = 0; n_pops = 0;
        @(negedge clock);
        reset = 1'b1; imem_req_ready = 1'b1;
        exp_q.push_back(32'h0);
        step(1);
        #2 chk("t6_reboot_addr", imem_req_addr, 32'h0);
        step(1);
        imem_req_ready = 1'b0;
        step(8);
        chk("t6_drained", 32'(exp_q.size()), 32'd0);
        chk("t6_pops", 32'(n_pops), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this bound.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
